// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and limits for the FIFO write-side arbiter
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   localparam int BEAT_CNT_W      = 4;
   localparam int NREQ_MIN        = 2;
   localparam int NREQ_MAX        = 8;
   localparam int BURST_MIN       = 1;
   localparam int BURST_MAX_LIMIT = 15;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester streams, FIFO write pins and grant status
interface fifo_wr_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int BITWID = 5
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]        req_vld;
   logic [NREQ*BITWID-1:0] req_data;
   logic [NREQ-1:0]        req_rdy;
   logic                   fifo_full;
   logic                   fifo_almost_full;
   logic                   fifo_wr_en;
   logic [BITWID-1:0]      fifo_wr_data;
   logic                   grant_vld;
   logic [IDW-1:0]         grant_id;

   modport master (
      output req_vld, req_data, fifo_full, fifo_almost_full,
      input  req_rdy, fifo_wr_en, fifo_wr_data, grant_vld, grant_id
   );

   modport slave (
      input  req_vld, req_data, fifo_full, fifo_almost_full,
      output req_rdy, fifo_wr_en, fifo_wr_data, grant_vld, grant_id
   );

endinterface

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational round-robin pick, first request above last
module rr_arb_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [$clog2(NREQ)-1:0] pick,
   output logic                    any
);
   localparam int IDW = $clog2(NREQ);

   logic           found;
   logic [IDW-1:0] idx;

   // k runs to NREQ so the previous owner is considered last, not skipped
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(last) + k) % NREQ);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst scheduler for one FIFO write port
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int BITWID    = 5,
   parameter int BURST_MAX = 4
) (
   input  logic           wclk,
   input  logic           rst_n,
   fifo_wr_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NREQ);

   if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
      $error("fifo_wr_arbiter: NREQ out of range");
   end
   if (BURST_MAX < BURST_MIN || BURST_MAX > BURST_MAX_LIMIT) begin : g_bad_burst
      $error("fifo_wr_arbiter: BURST_MAX out of range");
   end

   arb_state_e            state_q, state_d;
   logic [IDW-1:0]        owner_q, owner_d;
   logic [IDW-1:0]        last_owner_q, last_owner_d;
   logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d, beat_cnt_inc;
   logic                  wr_en_q, wr_en_d;
   logic [BITWID-1:0]     wr_data_q, wr_data_d;

   logic [IDW-1:0]        pick;
   logic                  any_req;
   logic                  owner_vld;
   logic                  owner_rdy;
   logic [NREQ-1:0]       rdy;
   logic [BITWID-1:0]     slice [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign slice[i] = bus.req_data[i*BITWID +: BITWID];
   end

   rr_arb_pick #(.NREQ(NREQ)) u_pick (
      .req  (bus.req_vld),
      .last (last_owner_q),
      .pick (pick),
      .any  (any_req)
   );

   assign owner_vld    = bus.req_vld[owner_q];
   // a write still sitting in the output register needs the last free slot
   assign owner_rdy    = !bus.fifo_full && !(bus.fifo_almost_full && wr_en_q);
   assign beat_cnt_inc = beat_cnt_q + BEAT_CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      beat_cnt_d   = beat_cnt_q;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
      rdy          = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d    = pick;
               beat_cnt_d = '0;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            rdy[owner_q] = owner_rdy;
            if (!owner_vld) begin
               state_d      = ST_IDLE;
               last_owner_d = owner_q;
            end else if (owner_rdy) begin
               wr_en_d    = 1'b1;
               wr_data_d  = slice[owner_q];
               beat_cnt_d = beat_cnt_inc;
               if (beat_cnt_inc == BEAT_CNT_W'(BURST_MAX)) begin
                  state_d      = ST_IDLE;
                  last_owner_d = owner_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_owner_q <= IDW'(NREQ - 1);
         beat_cnt_q   <= '0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         beat_cnt_q   <= beat_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign bus.req_rdy      = rdy;
   assign bus.fifo_wr_en   = wr_en_q;
   assign bus.fifo_wr_data = wr_data_q;
   assign bus.grant_vld    = (state_q == ST_GRANT);
   assign bus.grant_id     = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed bench with producer and depth-8 FIFO models
module tb_fifo_wr_arbiter;
   localparam int NREQ      = 4;
   localparam int BITWID    = 5;
   localparam int BURST_MAX = 4;
   localparam int DEPTH     = 8;

   logic wclk = 1'b0;
   logic rst_n;
   always #5 wclk = ~wclk;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .BITWID(BITWID)) bus ();

   fifo_wr_arbiter #(.NREQ(NREQ), .BITWID(BITWID), .BURST_MAX(BURST_MAX)) dut (
      .wclk  (wclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int                sent [NREQ];
   int                lim  [NREQ];
   logic [BITWID-1:0] base [NREQ];
   int                fcount;
   int                ovf;
   logic              rd_en;
   logic [BITWID-1:0] wlog [$];
   int                glog [$];
   logic              gv_prev = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   // producer i offers beat base+sent while sent < lim
   always_comb begin
      bus.req_vld  = '0;
      bus.req_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_vld[i] = (sent[i] < lim[i]);
         bus.req_data[i*BITWID +: BITWID] = base[i] + BITWID'(sent[i]);
      end
   end

   assign bus.fifo_full        = (fcount >= DEPTH);
   assign bus.fifo_almost_full = (fcount >= DEPTH - 1);

   always @(posedge wclk) begin
      int nxt;
      for (int i = 0; i < NREQ; i++)
         if (bus.req_vld[i] && bus.req_rdy[i]) sent[i] <= sent[i] + 1;
      if (bus.fifo_wr_en) begin
         wlog.push_back(bus.fifo_wr_data);
         if (fcount >= DEPTH) ovf <= ovf + 1;
      end
      nxt = fcount;
      if (bus.fifo_wr_en && fcount < DEPTH) nxt = nxt + 1;
      if (rd_en && fcount > 0) nxt = nxt - 1;
      fcount <= rst_n ? nxt : 0;
   end

   always @(negedge wclk) begin
      if (bus.grant_vld && !gv_prev) glog.push_back(int'(bus.grant_id));
      gv_prev = bus.grant_vld;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge wclk);
   endtask

   task automatic arm(input int i, input int n, input int start);
      base[i] = BITWID'(start - sent[i]);
      lim[i]  = sent[i] + n;
   endtask

   function automatic bit all_done();
      bit d = 1'b1;
      for (int i = 0; i < NREQ; i++) if (sent[i] < lim[i]) d = 1'b0;
      return d;
   endfunction

   task automatic wait_done(input string tag, input int max);
      int c = 0;
      while (!all_done() && c < max) begin
         tick(1);
         c++;
      end
      check(tag, int'(all_done()), 1);
      tick(4);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int w0, g0, k, e;
      logic [13:0] trace;

      // reset with every requester asking
      rst_n = 1'b0;
      rd_en = 1'b1;
      for (int i = 0; i < NREQ; i++) arm(i, 1, i);
      tick(2);
      check("t1_rst_wr_en",   int'(bus.fifo_wr_en),   0);
      check("t1_rst_wr_data", int'(bus.fifo_wr_data), 0);
      check("t1_rst_gv",      int'(bus.grant_vld),    0);
      check("t1_rst_gid",     int'(bus.grant_id),     0);
      check("t1_rst_rdy",     int'(bus.req_rdy),      0);
      rst_n = 1'b1;
      check("t1_idle_rdy",    int'(bus.req_rdy),      0);
      tick(1);
      check("t1_first_gv",    int'(bus.grant_vld),    1);
      check("t1_first_gid",   int'(bus.grant_id),     0);
      check("t1_first_rdy",   int'(bus.req_rdy),      1);
      wait_done("t1_drain", 50);

      // single stream, bursts of 4/4/2
      do_reset();
      w0 = wlog.size();
      arm(1, 10, 0);
      for (int j = 0; j < 14; j++) begin
         tick(1);
         trace[j] = bus.fifo_wr_en;
      end
      check("t2_wr_trace", int'(trace), int'(14'b01101111011110));
      wait_done("t2_drain", 50);
      check("t2_count", wlog.size() - w0, 10);
      for (int j = 0; j < 10; j++)
         check("t2_data", (w0 + j < wlog.size()) ? int'(wlog[w0 + j]) : -1, j);

      // round-robin with everyone requesting
      do_reset();
      w0 = wlog.size();
      g0 = glog.size();
      for (int i = 0; i < NREQ; i++) arm(i, 8, i * 8);
      wait_done("t3_drain", 100);
      for (int j = 0; j < 5; j++)
         check("t3_grant", (g0 + j < glog.size()) ? glog[g0 + j] : -1, j % NREQ);
      check("t3_count", wlog.size() - w0, 32);
      for (int n = 0; n < 32; n++) begin
         k = n / 4;
         e = (k % 4) * 8 + (k / 4) * 4 + (n % 4);
         check("t3_data", (w0 + n < wlog.size()) ? int'(wlog[w0 + n]) : -1, e);
      end

      // backpressure with the reader stopped
      do_reset();
      rd_en = 1'b0;
      w0 = wlog.size();
      arm(2, 20, 0);
      tick(20);
      check("t4_writes_full", wlog.size() - w0, 8);
      check("t4_fcount",      fcount, 8);
      check("t4_gv_held",     int'(bus.grant_vld), 1);
      check("t4_gid_held",    int'(bus.grant_id),  2);
      check("t4_rdy_full",    int'(bus.req_rdy),   0);
      rd_en = 1'b1;
      tick(3);
      rd_en = 1'b0;
      tick(10);
      check("t4_writes_more", wlog.size() - w0, 11);
      check("t4_last_data",   (w0 + 10 < wlog.size()) ? int'(wlog[w0 + 10]) : -1, 10);
      check("t4_ovf",         ovf, 0);
      lim[2] = sent[2];
      rd_en  = 1'b1;
      wait_done("t4_drain", 10);
      tick(10);

      // early release by requester 0
      do_reset();
      w0 = wlog.size();
      g0 = glog.size();
      arm(0, 2, 0);
      arm(1, 4, 8);
      arm(3, 4, 24);
      tick(1);
      check("t5_gv0",   int'(bus.grant_vld), 1);
      check("t5_gid0",  int'(bus.grant_id),  0);
      tick(2);
      check("t5_gv_b2", int'(bus.grant_vld), 1);
      tick(1);
      check("t5_idle",  int'(bus.grant_vld), 0);
      check("t5_idle_rdy", int'(bus.req_rdy), 0);
      tick(1);
      check("t5_gv1",   int'(bus.grant_vld), 1);
      check("t5_gid1",  int'(bus.grant_id),  1);
      wait_done("t5_drain", 50);
      check("t5_g0", (g0 < glog.size())     ? glog[g0]     : -1, 0);
      check("t5_g1", (g0 + 1 < glog.size()) ? glog[g0 + 1] : -1, 1);
      check("t5_g2", (g0 + 2 < glog.size()) ? glog[g0 + 2] : -1, 3);
      check("t5_count", wlog.size() - w0, 10);

      // reset during beat 2 of requester 3
      do_reset();
      w0 = wlog.size();
      arm(3, 4, 24);
      tick(2);
      check("t6_inflight", int'(bus.fifo_wr_en), 1);
      rst_n = 1'b0;
      tick(1);
      check("t6_rst_wr_en",   int'(bus.fifo_wr_en),   0);
      check("t6_rst_wr_data", int'(bus.fifo_wr_data), 0);
      check("t6_rst_gv",      int'(bus.grant_vld),    0);
      arm(0, 2, 0);
      rst_n = 1'b1;
      tick(1);
      check("t6_gv",  int'(bus.grant_vld), 1);
      check("t6_gid", int'(bus.grant_id),  0);
      wait_done("t6_drain", 50);
      check("t6_count", wlog.size() - w0, 5);
      check("t6_d0", (w0 < wlog.size())     ? int'(wlog[w0])     : -1, 24);
      check("t6_d1", (w0 + 1 < wlog.size()) ? int'(wlog[w0 + 1]) : -1, 0);
      check("t6_d3", (w0 + 3 < wlog.size()) ? int'(wlog[w0 + 3]) : -1, 26);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
